// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the register file write port. After reset it clears every register
// to zero (one write per cycle, ascending addresses), then arbitrates the
// port round-robin among NREQ writeback requesters.
//
// Handshake: requester i transfers in a cycle where reqValid[i] && grant[i].
// grant is combinational from reqValid and the round-robin pointer, and is
// only ever asserted towards a requester whose reqValid is high. The
// resulting write appears on writeEnable/writeReg/writeData the next cycle.
//
// Optional feature macro: REGFILE_WRITE_ARBITER_BYPASS_EN adds two read-side
// forwarding paths that return the in-flight write data for a matching
// read address.
module regfile_write_arbiter #(
  parameter int n    = 32,
  parameter int r    = 7,
  parameter int NREQ = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   reqValid,
  input  logic [NREQ*r-1:0] reqReg,
  input  logic [NREQ*n-1:0] reqData,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              writeEnable,
  output logic [r-1:0]      writeReg,
  output logic [n-1:0]      writeData
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
  ,
  input  logic [r-1:0]      readReg1,
  input  logic [r-1:0]      readReg2,
  input  logic [n-1:0]      readData1,
  input  logic [n-1:0]      readData2,
  output logic [n-1:0]      fwdData1,
  output logic [n-1:0]      fwdData2
`endif
);

  // Pointer width; wraps at NREQ-1, not at a power of two.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Last clear address; clearCnt carries an extra bit so this never wraps.
  localparam logic [r:0] LAST_ADDR = {1'b0, {r{1'b1}}};

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_t;

  state_t          state_q;
  logic [r:0]      clear_cnt_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   rr_ptr_d;
  logic            busy_q;
  logic            we_q;
  logic [r-1:0]    wreg_q;
  logic [n-1:0]    wdata_q;

  logic [NREQ-1:0] arb_grant;
  logic            arb_fire;
  logic [PW-1:0]   win_idx;
  logic [r-1:0]    sel_reg;
  logic [n-1:0]    sel_data;

  // Round-robin pick: first valid requester scanning from rr_ptr_q upward,
  // modulo NREQ. Suppressed entirely while the clear sequence runs.
  always_comb begin
    int idx;
    arb_grant = '0;
    arb_fire  = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!arb_fire && (j == idx) && reqValid[j]) begin
          arb_fire     = 1'b1;
          arb_grant[j] = 1'b1;
          win_idx      = PW'(j);
        end
      end
    end
    if (state_q != ARB) begin
      arb_grant = '0;
      arb_fire  = 1'b0;
    end
  end

  // Winner's destination/data, and the pointer position just past the winner.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (arb_grant[j]) begin
        sel_reg  = reqReg[j*r +: r];
        sel_data = reqData[j*n +: n];
      end
    end
    if (win_idx == PW'(NREQ - 1)) rr_ptr_d = '0;
    else                          rr_ptr_d = win_idx + 1'b1;
  end

  // Control FSM: clear every register after reset, then register granted writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      clear_cnt_q <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b1;
      we_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        INIT: begin
          we_q        <= 1'b1;
          wreg_q      <= clear_cnt_q[r-1:0];
          wdata_q     <= '0;
          clear_cnt_q <= clear_cnt_q + 1'b1;
          if (clear_cnt_q == LAST_ADDR) begin
            state_q <= ARB;
            busy_q  <= 1'b0;
          end
        end
        ARB: begin
          we_q <= arb_fire;
          if (arb_fire) begin
            wreg_q   <= sel_reg;
            wdata_q  <= sel_data;
            rr_ptr_q <= rr_ptr_d;
          end
        end
      endcase
    end
  end

  assign grant       = arb_grant;
  assign busy        = busy_q;
  assign writeEnable = we_q;
  assign writeReg    = wreg_q;
  assign writeData   = wdata_q;

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
  // Forward the write currently on the port so readers see it one cycle early.
  always_comb begin
    fwdData1 = readData1;
    fwdData2 = readData2;
    if (we_q && (wreg_q == readReg1)) fwdData1 = wdata_q;
    if (we_q && (wreg_q == readReg2)) fwdData2 = wdata_q;
  end
`endif

endmodule
